// File: rtl/drc_burst_scheduler.sv
// Splits DMA write requests into 4 KB-safe INCR bursts and hands the resulting
// descriptors round-robin to the per-path burst FIFOs of the AXI pusher.
module drc_burst_scheduler #(
  parameter int p_paths     = 2,
  parameter int p_max_beats = 256
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic [23:0]        req_beats,
  output logic [p_paths-1:0] paths_burst_wr,
  output logic [39:0]        paths_burst_out,
  input  logic [p_paths-1:0] paths_burst_full,
  output logic               busy,
  output logic               done,
  output logic [15:0]        bursts_issued
);

  localparam int PW = (p_paths > 1) ? $clog2(p_paths) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SPLIT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [8:0]         MAX_BEATS = 9'(p_max_beats);
  localparam logic [p_paths-1:0] WR_ONE    = p_paths'(1);

  logic [1:0]  state;
  logic [31:0] cur_addr;
  logic [23:0] rem;
  logic [PW-1:0] rr_ptr;

  logic [8:0] to_4k;
  logic [8:0] rem_clip;
  logic [8:0] lim;
  logic [8:0] blen;

  logic [2*p_paths-1:0] free2;
  logic [p_paths-1:0]   rot;
  logic                 found;
  int                   sel_int;
  int                   nxt_int;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        next_ptr;

  // Byte-offset bits of the request address carry no meaning for 128-bit beats.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^req_addr[3:0];

  // Burst length is the tightest of remaining beats, the configured cap and the 4 KB page end.
  always_comb begin
    to_4k    = 9'd256 - {1'b0, cur_addr[11:4]};
    rem_clip = (rem > 24'd256) ? 9'd256 : rem[8:0];
    lim      = (to_4k < MAX_BEATS) ? to_4k : MAX_BEATS;
    blen     = (rem_clip < lim) ? rem_clip : lim;
  end

  // Rotate the free mask so bit 0 is rr_ptr; the lowest set bit is the next path in turn.
  always_comb begin
    free2   = {~paths_burst_full, ~paths_burst_full};
    rot     = p_paths'(free2 >> rr_ptr);
    found   = 1'b0;
    sel_int = 0;
    for (int j = p_paths - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found   = 1'b1;
        sel_int = int'(rr_ptr) + j;
      end
    end
    if (sel_int >= p_paths) sel_int = sel_int - p_paths;
    nxt_int = sel_int + 1;
    if (nxt_int >= p_paths) nxt_int = 0;
    sel      = PW'(sel_int);
    next_ptr = PW'(nxt_int);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      cur_addr        <= 32'h0;
      rem             <= 24'h0;
      rr_ptr          <= '0;
      req_ready       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      paths_burst_wr  <= '0;
      paths_burst_out <= 40'h0;
      bursts_issued   <= 16'h0;
    end else begin
      paths_burst_wr <= '0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cur_addr  <= {req_addr[31:4], 4'h0};
            rem       <= req_beats;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_beats == 24'h0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SPLIT;
            end
          end
        end
        SPLIT: begin
          if (found) begin
            paths_burst_out <= {cur_addr, blen[7:0]};
            paths_burst_wr  <= WR_ONE << sel;
            rr_ptr          <= next_ptr;
            cur_addr        <= cur_addr + {19'h0, blen, 4'h0};
            rem             <= rem - {15'h0, blen};
            state           <= WRITE;
          end
        end
        WRITE: begin
          bursts_issued <= bursts_issued + 16'd1;
          if (rem == 24'h0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= SPLIT;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drc_burst_scheduler.sv
// Directed bench for drc_burst_scheduler: a default instance (256-beat cap, 2 paths)
// and a second instance with a 64-beat cap for the length-limit case.
module tb_drc_burst_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid64 = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [23:0] req_beats = 24'h0;
  logic [1:0]  full = 2'b00;
  logic [1:0]  full64 = 2'b00;

  logic        req_ready, busy, done;
  logic [1:0]  wr;
  logic [39:0] desc;
  logic [15:0] bursts;

  logic        req_ready64, busy64, done64;
  logic [1:0]  wr64;
  logic [39:0] desc64;
  logic [15:0] bursts64;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  drc_burst_scheduler dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_beats(req_beats),
    .paths_burst_wr(wr), .paths_burst_out(desc), .paths_burst_full(full),
    .busy(busy), .done(done), .bursts_issued(bursts)
  );

  drc_burst_scheduler #(.p_paths(2), .p_max_beats(64)) dut64 (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_valid(req_valid64), .req_ready(req_ready64),
    .req_addr(req_addr), .req_beats(req_beats),
    .paths_burst_wr(wr64), .paths_burst_out(desc64), .paths_burst_full(full64),
    .busy(busy64), .done(done64), .bursts_issued(bursts64)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  // Presents one request for a single cycle; on return the accept edge has passed.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [23:0] beats);
    req_addr  = addr;
    req_beats = beats;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput({tag, " ready after accept"}, 40'(req_ready), 40'd0);
    checkOutput({tag, " busy after accept"}, 40'(busy), 40'd1);
  endtask

  // Waits (bounded) for the next write strobe and checks its spacing, path and descriptor.
  task automatic expectWrite(input string tag, input logic [1:0] exp_wr, input logic [39:0] exp_desc,
                             input int exp_ticks);
    int n = 0;
    do begin
      tick();
      n++;
    end while (wr == 2'b00 && n < 40);
    checkOutput({tag, " latency"}, 40'(n), 40'(exp_ticks));
    checkOutput({tag, " wr"}, 40'(wr), 40'(exp_wr));
    checkOutput({tag, " desc"}, desc, exp_desc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0]  got_wr [3];
    logic [39:0] got_desc [3];
    int nw, writes, idle_seen, done_seen;

    // Reset state
    #2 i_rst = 1'b1;
    #1;
    checkOutput("rst req_ready", 40'(req_ready), 40'd1);
    checkOutput("rst busy", 40'(busy), 40'd0);
    checkOutput("rst done", 40'(done), 40'd0);
    checkOutput("rst wr", 40'(wr), 40'd0);
    checkOutput("rst desc", desc, 40'd0);
    checkOutput("rst bursts", 40'(bursts), 40'd0);
    tick();
    tick();
    i_rst = 1'b0;

    // Single burst
    $display("[TB] single burst");
    applyStimulus("single", 32'h0000_1000, 24'd16);
    checkOutput("single no early wr", 40'(wr), 40'd0);
    expectWrite("single", 2'b01, {32'h0000_1000, 8'h10}, 1);
    tick();
    checkOutput("single wr one cycle", 40'(wr), 40'd0);
    checkOutput("single done", 40'(done), 40'd1);
    checkOutput("single bursts", 40'(bursts), 40'd1);
    tick();
    checkOutput("single done pulse", 40'(done), 40'd0);
    checkOutput("single ready back", 40'(req_ready), 40'd1);
    checkOutput("single busy clear", 40'(busy), 40'd0);

    // 4 KB boundary split
    $display("[TB] 4KB split");
    doReset();
    applyStimulus("split4k", 32'h0000_0FF0, 24'd3);
    expectWrite("split4k b0", 2'b01, {32'h0000_0FF0, 8'h01}, 1);
    expectWrite("split4k b1", 2'b10, {32'h0000_1000, 8'h02}, 2);
    tick();
    checkOutput("split4k done", 40'(done), 40'd1);
    checkOutput("split4k bursts", 40'(bursts), 40'd2);
    tick();

    // 256-beat cap
    $display("[TB] max-length split");
    doReset();
    applyStimulus("max256", 32'h0, 24'd600);
    expectWrite("max256 b0", 2'b01, {32'h0000_0000, 8'h00}, 1);
    expectWrite("max256 b1", 2'b10, {32'h0000_1000, 8'h00}, 2);
    expectWrite("max256 b2", 2'b01, {32'h0000_2000, 8'h58}, 2);
    tick();
    checkOutput("max256 done", 40'(done), 40'd1);
    checkOutput("max256 bursts", 40'(bursts), 40'd3);
    tick();

    // 64-beat cap on the second instance
    $display("[TB] 64-beat cap");
    req_addr    = 32'h0;
    req_beats   = 24'd130;
    req_valid64 = 1'b1;
    tick();
    req_valid64 = 1'b0;
    nw = 0;
    writes = 0;
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      got_wr[k]   = 2'b00;
      got_desc[k] = 40'h0;
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      if (wr64 != 2'b00) begin
        writes++;
        if (nw < 3) begin
          got_wr[nw]   = wr64;
          got_desc[nw] = desc64;
          nw++;
        end
      end
      if (done64) done_seen++;
    end
    checkOutput("max64 write count", 40'(writes), 40'd3);
    checkOutput("max64 b0 wr", 40'(got_wr[0]), 40'd1);
    checkOutput("max64 b0 desc", got_desc[0], {32'h0000_0000, 8'h40});
    checkOutput("max64 b1 wr", 40'(got_wr[1]), 40'd2);
    checkOutput("max64 b1 desc", got_desc[1], {32'h0000_0400, 8'h40});
    checkOutput("max64 b2 wr", 40'(got_wr[2]), 40'd1);
    checkOutput("max64 b2 desc", got_desc[2], {32'h0000_0800, 8'h02});
    checkOutput("max64 bursts", 40'(bursts64), 40'd3);
    checkOutput("max64 done pulses", 40'(done_seen), 40'd1);

    // Backpressure
    $display("[TB] backpressure");
    doReset();
    full = 2'b11;
    applyStimulus("bp", 32'h0000_0FF0, 24'd2);
    writes = 0;
    idle_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (wr != 2'b00) writes++;
      if (!busy) idle_seen++;
    end
    checkOutput("bp no writes while full", 40'(writes), 40'd0);
    checkOutput("bp busy held", 40'(idle_seen), 40'd0);
    full = 2'b01;
    expectWrite("bp first", 2'b10, {32'h0000_0FF0, 8'h01}, 1);
    full = 2'b00;
    expectWrite("bp second", 2'b01, {32'h0000_1000, 8'h01}, 2);
    tick();
    checkOutput("bp done", 40'(done), 40'd1);
    checkOutput("bp bursts", 40'(bursts), 40'd2);
    tick();

    // Zero length
    $display("[TB] zero length");
    applyStimulus("zero", 32'h0000_0100, 24'd0);
    checkOutput("zero done at accept+1", 40'(done), 40'd1);
    checkOutput("zero no wr", 40'(wr), 40'd0);
    tick();
    checkOutput("zero done pulse", 40'(done), 40'd0);
    checkOutput("zero ready at accept+2", 40'(req_ready), 40'd1);
    checkOutput("zero bursts unchanged", 40'(bursts), 40'd2);

    // Async reset mid-transfer
    $display("[TB] async reset");
    doReset();
    applyStimulus("arst", 32'h0000_0FF0, 24'd300);
    expectWrite("arst b0", 2'b01, {32'h0000_0FF0, 8'h01}, 1);
    #3 i_rst = 1'b1;
    #1;
    checkOutput("arst wr cleared", 40'(wr), 40'd0);
    checkOutput("arst desc cleared", desc, 40'd0);
    checkOutput("arst ready", 40'(req_ready), 40'd1);
    checkOutput("arst busy", 40'(busy), 40'd0);
    checkOutput("arst bursts", 40'(bursts), 40'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    writes = 0;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (wr != 2'b00) writes++;
      if (done) done_seen++;
    end
    checkOutput("arst no writes after", 40'(writes), 40'd0);
    checkOutput("arst no done after", 40'(done_seen), 40'd0);
    applyStimulus("arst new", 32'h0000_300C, 24'd5);
    expectWrite("arst new", 2'b01, {32'h0000_3000, 8'h05}, 1);
    tick();
    checkOutput("arst new done", 40'(done), 40'd1);
    checkOutput("arst new bursts", 40'(bursts), 40'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
